channel_code_decoder: RTL and testbench

Receives the 3-bit priority channel codes produced by the spectrogram extractor's channel encoder (0 = no channel, n = channel n-1 highest active) and reconstructs per-channel information. It registers a one-hot channel vector for every accepted code. It also accumulates per-channel hit counts over fixed-length frames, presenting each completed frame as a spectrogram column through a valid/ready handshake. It sits on the readout side, between the code stream and the frame consumer (host interface or output serializer).

---
 rtl/channel_code_decoder_pkg.sv | 28 ++
 rtl/channel_code_decoder_hit_counter.sv | 47 ++++
 rtl/channel_code_decoder.sv | 136 +++++++++++++
 tb/tb_channel_code_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/channel_code_decoder_pkg.sv
// ---------------------------------------------------------------------------
// channel_code_decoder_pkg
//   Shared definitions for the priority channel code stream: the channel
//   count, code width, the "silent" code, and the code -> one-hot decode
//   that the encoder's verification model also uses.
// ---------------------------------------------------------------------------
package channel_code_decoder_pkg;

  localparam int NUM_CH = 7;
  localparam int CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [NUM_CH-1:0] onehot_t;

  localparam code_t CODE_SILENT = '0;

  // Code n (n >= 1) marks channel n-1 as the highest active channel, so
  // it maps to bit n-1. The silent code maps to an all-zero vector.
  function automatic onehot_t decodeOnehot(input code_t code);
    onehot_t oh;
    oh = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      oh[k] = (code != CODE_SILENT) && (code == code_t'(k + 1));
    end
    return oh;
  endfunction

endpackage

// File: rtl/channel_code_decoder_hit_counter.sv
// ---------------------------------------------------------------------------
// channel_hit_counter
//   One saturating per-channel hit counter.
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     inc         count one hit this cycle (ignored once saturated)
//     clr         clear to zero this cycle (wins over inc)
//     sat_next    value + inc with saturation, i.e. what the counter
//                 would hold after this cycle if it were not cleared
// ---------------------------------------------------------------------------
module channel_hit_counter
  import channel_code_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] sat_next
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             atMax;

  // Saturating increment; sat_next is exported so the frame snapshot can
  // include the hit that arrives in the same cycle the counter is cleared.
  always_comb begin
    atMax    = (count_q == {CNT_W{1'b1}});
    sat_next = count_q;
    if (inc && !atMax) begin
      sat_next = count_q + 1'b1;
    end
    count_d = clr ? '0 : sat_next;
  end

  // Counter register; clear takes priority so a new frame starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/channel_code_decoder.sv
// ---------------------------------------------------------------------------
// channel_code_decoder
//   Decodes the 3-bit priority channel codes into a registered one-hot
//   channel vector and accumulates per-channel hit counts over frames of
//   FRAME_LEN accepted codes. Each completed frame is offered as a
//   spectrogram column over a valid/ready handshake.
//   Ports:
//     clk, rst_n     clock and asynchronous active-low reset
//     code_valid     code is valid this cycle (always accepted)
//     code           channel code, 0 = silent, n = channel n-1
//     chan_onehot    one-hot of the last accepted code
//     chan_valid     one-cycle pulse, chan_onehot updated
//     frame_counts   snapshot, channel k at [k*CNT_W +: CNT_W]
//     frame_valid    snapshot available
//     frame_ready    consumer takes snapshot when high with frame_valid
//     frame_overrun  sticky: a snapshot was overwritten before being taken
//     overrun_clr    synchronous clear of frame_overrun
// ---------------------------------------------------------------------------
module channel_code_decoder
  import channel_code_decoder_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    code_valid,
  input  logic [CODE_W-1:0]       code,
  output logic [NUM_CH-1:0]       chan_onehot,
  output logic                    chan_valid,
  output logic [NUM_CH*CNT_W-1:0] frame_counts,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    frame_overrun,
  input  logic                    overrun_clr
);

  // FRAME_LEN is at most 65535, so the last sample index fits in 16 bits.
  localparam int            SAMPLE_W    = 16;
  localparam [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(FRAME_LEN - 1);

  logic [SAMPLE_W-1:0]     sampleCnt_q;
  logic [SAMPLE_W-1:0]     sampleCnt_d;
  logic [NUM_CH-1:0]       chanOnehot_q;
  logic                    chanValid_q;
  logic [NUM_CH*CNT_W-1:0] frameCounts_q;
  logic                    frameValid_q;
  logic                    frameValid_d;
  logic                    overrun_q;
  logic                    overrun_d;

  logic [NUM_CH-1:0]       decoded;
  logic [NUM_CH-1:0]       hitInc;
  logic [NUM_CH*CNT_W-1:0] satNextFlat;
  logic                    closeFrame;
  logic                    transfer;

  // Decode once and reuse it both for the one-hot output and as the
  // per-channel increment strobes; the silent code decodes to zero so it
  // bumps no counter.
  always_comb begin
    decoded    = decodeOnehot(code);
    hitInc     = code_valid ? decoded : '0;
    closeFrame = code_valid && (sampleCnt_q == LAST_SAMPLE);
    transfer   = frameValid_q && frame_ready;
  end

  // One saturating counter per channel, all cleared together at frame close.
  for (genvar k = 0; k < NUM_CH; k++) begin : gHit
    channel_hit_counter #(
      .CNT_W (CNT_W)
    ) uHit (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (hitInc[k]),
      .clr      (closeFrame),
      .sat_next (satNextFlat[k*CNT_W +: CNT_W])
    );
  end

  // Next-state for the sample counter, the frame handshake and the sticky
  // overrun flag. A frame close always leaves a snapshot pending; it counts
  // as an overrun only when the previous snapshot is still untaken. When an
  // overrun and a clear coincide the overrun wins.
  always_comb begin
    sampleCnt_d = sampleCnt_q;
    if (code_valid) begin
      sampleCnt_d = closeFrame ? '0 : sampleCnt_q + 1'b1;
    end

    frameValid_d = frameValid_q;
    if (closeFrame) begin
      frameValid_d = 1'b1;
    end else if (transfer) begin
      frameValid_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (closeFrame && frameValid_q && !frame_ready) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Registered state; the snapshot only changes at frame close, which keeps
  // frame_counts stable for the whole time frame_valid is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleCnt_q   <= '0;
      chanOnehot_q  <= '0;
      chanValid_q   <= 1'b0;
      frameCounts_q <= '0;
      frameValid_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sampleCnt_q  <= sampleCnt_d;
      chanValid_q  <= code_valid;
      frameValid_q <= frameValid_d;
      overrun_q    <= overrun_d;
      if (code_valid) begin
        chanOnehot_q <= decoded;
      end
      if (closeFrame) begin
        frameCounts_q <= satNextFlat;
      end
    end
  end

  assign chan_onehot   = chanOnehot_q;
  assign chan_valid    = chanValid_q;
  assign frame_counts  = frameCounts_q;
  assign frame_valid   = frameValid_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_channel_code_decoder.sv
// ---------------------------------------------------------------------------
// tb_channel_code_decoder
//   Directed bench for channel_code_decoder. Instance A uses FRAME_LEN=4,
//   CNT_W=8; instance B uses FRAME_LEN=8, CNT_W=2 for counter saturation.
// ---------------------------------------------------------------------------
module tb_channel_code_decoder;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A signals
  logic        aValid, aReady, aClr;
  logic [2:0]  aCode;
  logic [6:0]  aOnehot;
  logic        aChanValid, aFrameValid, aOverrun;
  logic [55:0] aCounts;

  // Instance B signals
  logic        bValid, bReady, bClr;
  logic [2:0]  bCode;
  logic [6:0]  bOnehot;
  logic        bChanValid, bFrameValid, bOverrun;
  logic [13:0] bCounts;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    bit          valid;
    logic [2:0]  code;
    bit          ready;
    logic [6:0]  expOh;
    bit          expCv;
    bit          expFv;
    logic [55:0] expCounts;
  } vec_t;

  vec_t vecs[10];

  // 100 MHz-style free-running clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  channel_code_decoder #(
    .FRAME_LEN (4),
    .CNT_W     (8)
  ) dutA (
    .clk           (clk),
    .rst_n         (rst_n),
    .code_valid    (aValid),
    .code          (aCode),
    .chan_onehot   (aOnehot),
    .chan_valid    (aChanValid),
    .frame_counts  (aCounts),
    .frame_valid   (aFrameValid),
    .frame_ready   (aReady),
    .frame_overrun (aOverrun),
    .overrun_clr   (aClr)
  );

  channel_code_decoder #(
    .FRAME_LEN (8),
    .CNT_W     (2)
  ) dutB (
    .clk           (clk),
    .rst_n         (rst_n),
    .code_valid    (bValid),
    .code          (bCode),
    .chan_onehot   (bOnehot),
    .chan_valid    (bChanValid),
    .frame_counts  (bCounts),
    .frame_valid   (bFrameValid),
    .frame_ready   (bReady),
    .frame_overrun (bOverrun),
    .overrun_clr   (bClr)
  );

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive instance A for one cycle.
  task automatic applyStimulus(input bit v, input logic [2:0] c,
                               input bit r, input bit clr);
    aValid = v;
    aCode  = c;
    aReady = r;
    aClr   = clr;
    tick();
  endtask

  task automatic checkA(input string tag, input logic [6:0] oh, input bit cv,
                        input bit fv, input logic [55:0] cnt, input bit ov);
    checkOutput({tag, ".onehot"},  64'(aOnehot),     64'(oh));
    checkOutput({tag, ".chanv"},   64'(aChanValid),  64'(cv));
    checkOutput({tag, ".framev"},  64'(aFrameValid), 64'(fv));
    checkOutput({tag, ".counts"},  64'(aCounts),     64'(cnt));
    checkOutput({tag, ".overrun"}, 64'(aOverrun),    64'(ov));
  endtask

  initial begin
    // Decode sequence 0,1,7,4 closing frame 1, then frame 3,3,0,5.
    vecs[0] = '{1'b1, 3'd0, 1'b1, 7'h00, 1'b1, 1'b0, 56'h0};
    vecs[1] = '{1'b1, 3'd1, 1'b1, 7'h01, 1'b1, 1'b0, 56'h0};
    vecs[2] = '{1'b1, 3'd7, 1'b1, 7'h40, 1'b1, 1'b0, 56'h0};
    vecs[3] = '{1'b1, 3'd4, 1'b1, 7'h08, 1'b1, 1'b1, 56'h01000001000001};
    vecs[4] = '{1'b0, 3'd0, 1'b1, 7'h08, 1'b0, 1'b0, 56'h01000001000001};
    vecs[5] = '{1'b1, 3'd3, 1'b1, 7'h04, 1'b1, 1'b0, 56'h01000001000001};
    vecs[6] = '{1'b1, 3'd3, 1'b1, 7'h04, 1'b1, 1'b0, 56'h01000001000001};
    vecs[7] = '{1'b1, 3'd0, 1'b1, 7'h00, 1'b1, 1'b0, 56'h01000001000001};
    vecs[8] = '{1'b1, 3'd5, 1'b1, 7'h10, 1'b1, 1'b1, 56'h00000100020000};
    vecs[9] = '{1'b0, 3'd0, 1'b1, 7'h10, 1'b0, 1'b0, 56'h00000100020000};

    rst_n  = 1'b0;
    aValid = 1'b0; aCode = 3'd0; aReady = 1'b0; aClr = 1'b0;
    bValid = 1'b0; bCode = 3'd0; bReady = 1'b0; bClr = 1'b0;

    // Reset state
    #12;
    checkA("reset", 7'h00, 1'b0, 1'b0, 56'h0, 1'b0);
    checkOutput("resetB.framev", 64'(bFrameValid), 64'd0);
    checkOutput("resetB.counts", 64'(bCounts), 64'd0);
    #10;
    rst_n = 1'b1;

    // Table-driven decode and frame accumulation
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].code, vecs[i].ready, 1'b0);
      checkA($sformatf("vec%0d", i), vecs[i].expOh, vecs[i].expCv,
             vecs[i].expFv, vecs[i].expCounts, 1'b0);
    end

    // Backpressure: first frame of code 1 stays pending
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    checkA("bp1", 7'h01, 1'b1, 1'b1, 56'h00000000000004, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    checkA("bpStable", 7'h02, 1'b1, 1'b1, 56'h00000000000004, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    // Overrun set coincides with a clear request: set must win
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b1);
    checkA("overrun", 7'h02, 1'b1, 1'b1, 56'h00000000000400, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkA("ovClr", 7'h02, 1'b0, 1'b1, 56'h00000000000400, 1'b0);

    // Transfer in the same cycle a new frame closes
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
    checkA("simul", 7'h04, 1'b1, 1'b1, 56'h00000000040000, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    checkA("simulTake", 7'h04, 1'b0, 1'b0, 56'h00000000040000, 1'b0);

    // Saturation on B: eight hits on channel 0 saturate a 2-bit counter at 3
    bValid = 1'b1; bCode = 3'd1; bReady = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checkOutput("satB.early", 64'(bFrameValid), 64'd0);
    tick();
    checkOutput("satB.framev", 64'(bFrameValid), 64'd1);
    checkOutput("satB.counts", 64'(bCounts), 64'h0003);
    // Next frame must start from zero: one channel-1 hit, seven silent
    bReady = 1'b1; bCode = 3'd2;
    tick();
    checkOutput("satB.take", 64'(bFrameValid), 64'd0);
    bCode = 3'd0;
    for (int i = 0; i < 7; i++) tick();
    checkOutput("satB2.framev", 64'(bFrameValid), 64'd1);
    checkOutput("satB2.counts", 64'(bCounts), 64'h0004);
    bReady = 1'b0; bValid = 1'b0;

    // Asynchronous reset two codes into a frame
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    checkA("preRst", 7'h01, 1'b1, 1'b0, 56'h00000000040000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkA("asyncRst", 7'h00, 1'b0, 1'b0, 56'h0, 1'b0);
    checkOutput("asyncRstB.framev", 64'(bFrameValid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd6, 1'b0, 1'b0);
    checkA("postRst3", 7'h20, 1'b1, 1'b0, 56'h0, 1'b0);
    applyStimulus(1'b1, 3'd6, 1'b0, 1'b0);
    checkA("postRst4", 7'h20, 1'b1, 1'b1, 56'h00040000000000, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
